// File: rtl/music_pkg.sv
// Shared types and constants for the music device sequencer blocks.
package music_pkg;

   localparam int NOTE_REST  = 0;
   localparam int DEF_NOTE_W = 4;
   localparam int DEF_OCT_W  = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REC,
      ST_PLAY
   } seq_state_e;

   typedef struct packed {
      logic [DEF_OCT_W-1:0]  octave;
      logic [DEF_NOTE_W-1:0] note;
   } note_entry_t;

endpackage

// File: rtl/note_sequencer_step_timer.sv
// step_timer: free-running 0..TICKS-1 counter with synchronous clear and a
// terminal-count flag that is valid while enabled on the last tick.
module step_timer #(
   parameter int  TICKS = 4,
   localparam int CW    = $clog2(TICKS)
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [CW-1:0] count;

   assign tc = en && (count == CW'(TICKS - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clr || tc)
         count <= '0;
      else if (en)
         count <= count + CW'(1);
   end

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: records {octave, note} entries and plays them back at a fixed
// step rate. Define NOTE_SEQUENCER_TRANSPOSE_EN to add a saturating octave transpose.
module note_sequencer
   import music_pkg::*;
#(
   parameter int  DEPTH      = 16,
   parameter int  NOTE_W     = 4,
   parameter int  OCT_W      = 2,
   parameter int  STEP_TICKS = 12500000,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rec_start,
   input  logic              play_start,
   input  logic              stop,
   input  logic              loop_en,
   input  logic              note_in_valid,
   input  logic [NOTE_W-1:0] note_in,
   input  logic [OCT_W-1:0]  octave_in,
`ifdef NOTE_SEQUENCER_TRANSPOSE_EN
   input  logic signed [OCT_W:0] transpose,
`endif
   output logic [NOTE_W-1:0] note_out,
   output logic [OCT_W-1:0]  octave_out,
   output logic              note_active,
   output logic              step_stb,
   output logic [AW-1:0]     play_idx,
   output logic [AW:0]       seq_len,
   output logic              recording,
   output logic              playing,
   output logic              full
);

   typedef struct packed {
      logic [OCT_W-1:0]  octave;
      logic [NOTE_W-1:0] note;
   } entry_t;

   entry_t           mem [DEPTH];
   seq_state_e       state;
   logic [AW-1:0]    wr_ptr;
   logic             prime;
   logic             tc;
   logic             last;
   logic             wr_en;
   logic [AW-1:0]    next_idx;
   entry_t           next_e;
   logic [OCT_W-1:0] next_oct;

   assign recording = (state == ST_REC);
   assign playing   = (state == ST_PLAY);
   assign full      = (seq_len == (AW+1)'(DEPTH));
   assign last      = ({1'b0, play_idx} == seq_len - (AW+1)'(1));
   // prime marks the first presentation after entering PLAY, which always shows entry 0
   assign next_idx  = (prime || last) ? '0 : play_idx + AW'(1);
   assign next_e    = mem[next_idx];
   assign wr_en     = recording && note_in_valid && !stop && !rec_start;

`ifdef NOTE_SEQUENCER_TRANSPOSE_EN
   logic signed [OCT_W+1:0] oct_sum;
   assign oct_sum = $signed({2'b00, next_e.octave}) + $signed({transpose[OCT_W], transpose});
   always_comb begin
      next_oct = oct_sum[OCT_W-1:0];
      if (oct_sum[OCT_W+1])
         next_oct = '0;
      else if (oct_sum[OCT_W])
         next_oct = '1;
   end
`else
   assign next_oct = next_e.octave;
`endif

   step_timer #(.TICKS(STEP_TICKS)) u_step_timer (
      .clk   (clk),
      .reset (reset),
      .clr   (!playing),
      .en    (playing && !prime),
      .tc    (tc)
   );

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= {octave_in, note_in};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         seq_len     <= '0;
         wr_ptr      <= '0;
         play_idx    <= '0;
         prime       <= 1'b0;
         note_out    <= '0;
         octave_out  <= '0;
         note_active <= 1'b0;
         step_stb    <= 1'b0;
      end else begin
         step_stb <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (stop) begin
                  state <= ST_IDLE;
               end else if (rec_start) begin
                  state   <= ST_REC;
                  seq_len <= '0;
                  wr_ptr  <= '0;
               end else if (play_start && seq_len != '0) begin
                  state    <= ST_PLAY;
                  play_idx <= '0;
                  prime    <= 1'b1;
               end
            end
            ST_REC: begin
               if (stop) begin
                  state <= ST_IDLE;
               end else if (rec_start) begin
                  seq_len <= '0;
                  wr_ptr  <= '0;
               end else if (note_in_valid) begin
                  wr_ptr  <= wr_ptr + AW'(1);
                  seq_len <= seq_len + (AW+1)'(1);
                  if (seq_len == (AW+1)'(DEPTH - 1))
                     state <= ST_IDLE;
               end
            end
            ST_PLAY: begin
               if (stop || rec_start || (tc && last && !loop_en)) begin
                  state       <= (rec_start && !stop) ? ST_REC : ST_IDLE;
                  play_idx    <= '0;
                  prime       <= 1'b0;
                  note_out    <= NOTE_W'(NOTE_REST);
                  octave_out  <= '0;
                  note_active <= 1'b0;
                  if (rec_start && !stop) begin
                     seq_len <= '0;
                     wr_ptr  <= '0;
                  end
               end else if (prime || tc) begin
                  prime       <= 1'b0;
                  play_idx    <= next_idx;
                  note_out    <= next_e.note;
                  octave_out  <= next_oct;
                  note_active <= 1'b1;
                  step_stb    <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer (DEPTH=4, STEP_TICKS=4) against a
// queue-based playback model; covers transpose when NOTE_SEQUENCER_TRANSPOSE_EN is set.
module tb_note_sequencer;

   localparam int DEPTH  = 4;
   localparam int NOTE_W = 4;
   localparam int OCT_W  = 2;
   localparam int ST     = 4;
   localparam int AW     = 2;
   localparam int PW     = 3 + AW + OCT_W + NOTE_W;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              rec_start = 1'b0;
   logic              play_start = 1'b0;
   logic              stop = 1'b0;
   logic              loop_en = 1'b0;
   logic              note_in_valid = 1'b0;
   logic [NOTE_W-1:0] note_in = '0;
   logic [OCT_W-1:0]  octave_in = '0;
`ifdef NOTE_SEQUENCER_TRANSPOSE_EN
   logic signed [OCT_W:0] transpose = '0;
`endif
   logic [NOTE_W-1:0] note_out;
   logic [OCT_W-1:0]  octave_out;
   logic              note_active;
   logic              step_stb;
   logic [AW-1:0]     play_idx;
   logic [AW:0]       seq_len;
   logic              recording;
   logic              playing;
   logic              full;

   int n_cmp = 0;
   int n_bad = 0;

   logic [NOTE_W-1:0] m_note[$];
   logic [OCT_W-1:0]  m_oct[$];

   note_sequencer #(.DEPTH(DEPTH), .NOTE_W(NOTE_W), .OCT_W(OCT_W), .STEP_TICKS(ST)) dut (
      .clk           (clk),
      .reset         (reset),
      .rec_start     (rec_start),
      .play_start    (play_start),
      .stop          (stop),
      .loop_en       (loop_en),
      .note_in_valid (note_in_valid),
      .note_in       (note_in),
      .octave_in     (octave_in),
`ifdef NOTE_SEQUENCER_TRANSPOSE_EN
      .transpose     (transpose),
`endif
      .note_out      (note_out),
      .octave_out    (octave_out),
      .note_active   (note_active),
      .step_stb      (step_stb),
      .play_idx      (play_idx),
      .seq_len       (seq_len),
      .recording     (recording),
      .playing       (playing),
      .full          (full)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [OCT_W-1:0] exp_oct(input logic [OCT_W-1:0] o);
`ifdef NOTE_SEQUENCER_TRANSPOSE_EN
      int v;
      v = int'(o) + int'(transpose);
      if (v < 0) v = 0;
      if (v > (1 << OCT_W) - 1) v = (1 << OCT_W) - 1;
      return OCT_W'(v);
`else
      return o;
`endif
   endfunction

   // Expected {playing, note_active, step_stb, play_idx, octave, note} c cycles after the first step
   function automatic logic [PW-1:0] exp_play(input int c, input bit lp);
      int s, len, idx;
      s   = c / ST;
      len = m_note.size();
      if (len == 0 || (!lp && s >= len)) return '0;
      idx = s % len;
      return {1'b1, 1'b1, (c % ST == 0), AW'(idx), exp_oct(m_oct[idx]), m_note[idx]};
   endfunction

   task automatic record_seq(input int n, input bit fixed);
      int fn[3] = '{1, 5, 9};
      int fo[3] = '{0, 1, 2};
      m_note.delete();
      m_oct.delete();
      rec_start = 1'b1; tick(); rec_start = 1'b0;
      n_cmp++;
      if (recording !== 1'b1 || seq_len !== '0) begin
         n_bad++;
         $display("FAIL rec_enter: recording=%0b seq_len=%0d, expected 1/0", recording, seq_len);
      end
      for (int i = 0; i < n; i++) begin
         note_in       = fixed ? NOTE_W'(fn[i]) : NOTE_W'($urandom);
         octave_in     = fixed ? OCT_W'(fo[i]) : OCT_W'($urandom);
         note_in_valid = 1'b1;
         m_note.push_back(note_in);
         m_oct.push_back(octave_in);
         tick();
         note_in_valid = 1'b0;
         n_cmp++;
         if (seq_len !== (AW+1)'(i + 1) || full !== (i + 1 == DEPTH) || recording !== (i + 1 < DEPTH)) begin
            n_bad++;
            $display("FAIL rec_write%0d: seq_len=%0d full=%0b rec=%0b, expected %0d/%0b/%0b",
                     i, seq_len, full, recording, i + 1, (i + 1 == DEPTH), (i + 1 < DEPTH));
         end
         repeat ($urandom_range(0, 2)) tick();
      end
      stop = 1'b1; tick(); stop = 1'b0;
      n_cmp++;
      if (recording !== 1'b0 || seq_len !== (AW+1)'(n)) begin
         n_bad++;
         $display("FAIL rec_stop: recording=%0b seq_len=%0d, expected 0/%0d", recording, seq_len, n);
      end
   endtask

   task automatic play_and_check(input bit lp, input int ncyc, input string tag);
      int lat;
      logic [PW-1:0] obs, exp;
      loop_en = lp;
      play_start = 1'b1; tick(); play_start = 1'b0;
      lat = 1;
      n_cmp++;
      if (playing !== 1'b1 || step_stb !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_enter: playing=%0b step_stb=%0b, expected 1/0", tag, playing, step_stb);
      end
      while (step_stb !== 1'b1 && lat < 10) begin
         tick();
         lat++;
      end
      n_cmp++;
      if (lat != 2) begin
         n_bad++;
         $display("FAIL %s_latency: first step_stb after %0d cycles, expected 2", tag, lat);
         return;
      end
      for (int c = 0; c < ncyc; c++) begin
         obs = {playing, note_active, step_stb, play_idx, octave_out, note_out};
         exp = exp_play(c, lp);
         n_cmp++;
         if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s_cycle%0d: {play,act,stb,idx,oct,note}=%h, expected %h", tag, c, obs, exp);
         end
         tick();
      end
   endtask

   task automatic stop_and_check(input string tag);
      stop = 1'b1; tick(); stop = 1'b0;
      n_cmp++;
      if (playing !== 1'b0 || note_out !== '0 || octave_out !== '0 || note_active !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_stop: playing=%0b note=%0d oct=%0d act=%0b, expected all 0",
                  tag, playing, note_out, octave_out, note_active);
      end
   endtask

   task automatic test_reset();
      repeat (2) tick();
      n_cmp++;
      if ({playing, recording, full, note_active, step_stb, note_out, octave_out, play_idx, seq_len} !== '0) begin
         n_bad++;
         $display("FAIL reset_state: outputs not all zero (play=%0b rec=%0b len=%0d note=%0d)",
                  playing, recording, seq_len, note_out);
      end
      reset = 1'b0;
      tick();
      n_cmp++;
      if (playing !== 1'b0 || recording !== 1'b0 || seq_len !== '0) begin
         n_bad++;
         $display("FAIL reset_release: play=%0b rec=%0b len=%0d, expected 0/0/0", playing, recording, seq_len);
      end
   endtask

   task automatic test_record();
      record_seq(3, 1'b1);
      n_cmp++;
      if (full !== 1'b0) begin
         n_bad++;
         $display("FAIL record_full: full=%0b, expected 0", full);
      end
      note_in_valid = 1'b1; tick(); note_in_valid = 1'b0;
      n_cmp++;
      if (seq_len !== 3'd3 || recording !== 1'b0) begin
         n_bad++;
         $display("FAIL valid_outside_rec: seq_len=%0d rec=%0b, expected 3/0", seq_len, recording);
      end
   endtask

   task automatic test_oneshot();
      play_and_check(1'b0, 3 * ST + 2, "oneshot");
   endtask

   task automatic test_loop();
      play_and_check(1'b1, 3 * ST + 3, "loop");
      stop_and_check("loop");
   endtask

   task automatic test_autofull();
      record_seq(DEPTH, 1'b0);
      note_in = 4'hF; octave_in = 2'd3;
      note_in_valid = 1'b1; tick(); note_in_valid = 1'b0;
      n_cmp++;
      if (seq_len !== (AW+1)'(DEPTH) || full !== 1'b1) begin
         n_bad++;
         $display("FAIL autofull_extra: seq_len=%0d full=%0b, expected %0d/1", seq_len, full, DEPTH);
      end
      play_and_check(1'b1, 2 * DEPTH * ST, "fullplay");
      stop_and_check("fullplay");
   endtask

   task automatic test_boundary();
      rec_start = 1'b1; play_start = 1'b1; tick(); rec_start = 1'b0; play_start = 1'b0;
      n_cmp++;
      if (recording !== 1'b1 || playing !== 1'b0 || seq_len !== '0) begin
         n_bad++;
         $display("FAIL rec_play_same: rec=%0b play=%0b len=%0d, expected 1/0/0", recording, playing, seq_len);
      end
      stop = 1'b1; tick(); stop = 1'b0;
      m_note.delete();
      m_oct.delete();
      play_start = 1'b1; tick(); play_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (playing !== 1'b0 || step_stb !== 1'b0 || note_active !== 1'b0 || seq_len !== '0) begin
            n_bad++;
            $display("FAIL play_empty%0d: play=%0b stb=%0b act=%0b len=%0d, expected 0/0/0/0",
                     i, playing, step_stb, note_active, seq_len);
         end
         tick();
      end
   endtask

   task automatic test_rec_during_play();
      record_seq(2, 1'b0);
      play_and_check(1'b1, ST + 1, "preabort");
      rec_start = 1'b1; tick(); rec_start = 1'b0;
      n_cmp++;
      if (recording !== 1'b1 || playing !== 1'b0 || note_out !== '0 || note_active !== 1'b0 || seq_len !== '0) begin
         n_bad++;
         $display("FAIL rec_in_play: rec=%0b play=%0b note=%0d act=%0b len=%0d, expected 1/0/0/0/0",
                  recording, playing, note_out, note_active, seq_len);
      end
      stop = 1'b1; tick(); stop = 1'b0;
   endtask

   task automatic test_random();
      int len;
      bit lp;
      for (int it = 0; it < 6; it++) begin
         len = $urandom_range(1, DEPTH);
         lp  = 1'($urandom_range(0, 1));
         record_seq(len, 1'b0);
         play_and_check(lp, lp ? 2 * len * ST + 3 : len * ST + 2, "random");
         if (lp) stop_and_check("random");
      end
   endtask

`ifdef NOTE_SEQUENCER_TRANSPOSE_EN
   task automatic test_transpose();
      m_note.delete();
      m_oct.delete();
      rec_start = 1'b1; tick(); rec_start = 1'b0;
      note_in = 4'd3; octave_in = 2'd2; note_in_valid = 1'b1; tick();
      note_in = 4'd4; octave_in = 2'd0; tick();
      note_in_valid = 1'b0;
      m_note.push_back(4'd3); m_oct.push_back(2'd2);
      m_note.push_back(4'd4); m_oct.push_back(2'd0);
      stop = 1'b1; tick(); stop = 1'b0;
      transpose = 3'sd3;
      play_and_check(1'b0, 2 * ST + 2, "transpose_up");
      transpose = -3'sd1;
      play_and_check(1'b0, 2 * ST + 2, "transpose_down");
      transpose = '0;
   endtask
`endif

   task automatic test_reset_mid_play();
      record_seq(3, 1'b0);
      play_and_check(1'b1, 6, "prereset");
      reset = 1'b1;
      #2;
      n_cmp++;
      if ({playing, recording, note_active, step_stb, note_out, octave_out, play_idx, seq_len, full} !== '0) begin
         n_bad++;
         $display("FAIL async_reset: play=%0b act=%0b note=%0d len=%0d, expected all 0",
                  playing, note_active, note_out, seq_len);
      end
      tick();
      reset = 1'b0;
      m_note.delete();
      m_oct.delete();
   endtask

   initial begin
      test_reset();
      test_record();
      test_oneshot();
      test_loop();
      test_autofull();
      test_boundary();
      test_rec_during_play();
      test_random();
`ifdef NOTE_SEQUENCER_TRANSPOSE_EN
      test_transpose();
`endif
      test_reset_mid_play();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
